// File: rtl/note_scheduler_if.sv
// Note request/acknowledge handshake and tone-generator drive bundle.
// The master side requests notes; the slave side is the scheduler.
interface note_scheduler_if;
    logic       lead_req;
    logic [6:0] lead_hp;
    logic       bass_req;
    logic [6:0] bass_hp;
    logic       lead_ack;
    logic       bass_ack;
    logic [6:0] synth_hp;
    logic       synth_active;
    logic       synth_clk;
    logic [6:0] slot_idx;

    modport master (
        output lead_req, lead_hp, bass_req, bass_hp,
        input  lead_ack, bass_ack, synth_hp, synth_active,
        input  synth_clk, slot_idx
    );

    modport slave (
        input  lead_req, lead_hp, bass_req, bass_hp,
        output lead_ack, bass_ack, synth_hp, synth_active,
        output synth_clk, slot_idx
    );
endinterface

// File: rtl/note_scheduler.sv
// Slot-based note scheduler: arbitrates lead/bass note requests at
// slot boundaries and gates the tone generator for part of each slot.
module note_scheduler #(
    parameter int PRESCALE_BITS = 18,
    parameter int SYNTH_BIT     = 10,
    parameter int SLOT_LEN      = 20,
    parameter int GATE_LEN      = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic silence,
    note_scheduler_if.slave bus
);
    localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);
    localparam logic [SW-1:0] GATE_LAST = SW'(GATE_LEN - 1);

    typedef enum logic [1:0] {IDLE, GATE, TAIL, REST} state_t;

    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     msb_q;
    logic [SW-1:0]            sub_ctr;
    logic [6:0]               slot_idx;
    logic                     last_lead;
    state_t                   state;
    logic [6:0]               synth_hp;
    logic                     lead_ack;
    logic                     bass_ack;

    logic msb;
    logic tick;
    logic boundary;
    logic grant_lead;
    logic grant_bass;

    assign msb = prescaler[PRESCALE_BITS-1];
    // msb_q holds while silenced, so a rising MSB caught by silence
    // still produces its tick once silence is released.
    assign tick = msb & ~msb_q & ~silence;
    assign boundary = tick && (sub_ctr == SLOT_LAST);

    // Round-robin: on a tie the side that did not win last goes next.
    assign grant_lead = bus.lead_req & (~bus.bass_req | ~last_lead);
    assign grant_bass = bus.bass_req & (~bus.lead_req | last_lead);

    // Free-running prescaler and MSB edge detector, frozen by silence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            msb_q     <= 1'b0;
        end else if (!silence) begin
            prescaler <= prescaler + 1'b1;
            msb_q     <= msb;
        end
    end

    // Position within the slot and the slot timestamp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_ctr  <= '0;
            slot_idx <= '0;
        end else if (tick) begin
            if (sub_ctr == SLOT_LAST) begin
                sub_ctr  <= '0;
                slot_idx <= slot_idx + 7'd1;
            end else begin
                sub_ctr <= sub_ctr + SW'(1);
            end
        end
    end

    // Note FSM with registered acks and half-period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            synth_hp  <= '0;
            lead_ack  <= 1'b0;
            bass_ack  <= 1'b0;
            last_lead <= 1'b0;
        end else begin
            lead_ack <= 1'b0;
            bass_ack <= 1'b0;
            if (boundary) begin
                if (grant_lead) begin
                    lead_ack  <= 1'b1;
                    synth_hp  <= bus.lead_hp;
                    last_lead <= 1'b1;
                    state     <= GATE;
                end else if (grant_bass) begin
                    bass_ack  <= 1'b1;
                    synth_hp  <= bus.bass_hp;
                    last_lead <= 1'b0;
                    state     <= GATE;
                end else begin
                    state <= REST;
                end
            end else if (tick && state == GATE && sub_ctr == GATE_LAST) begin
                state <= TAIL;
            end
        end
    end

    assign bus.lead_ack     = lead_ack;
    assign bus.bass_ack     = bass_ack;
    assign bus.synth_hp     = synth_hp;
    assign bus.synth_active = (state == GATE) & ~silence;
    assign bus.synth_clk    = prescaler[SYNTH_BIT];
    assign bus.slot_idx     = slot_idx;
endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a small prescaler so that
// ticks land on cycles 8, 24, 40, 56... after reset.
module tb_note_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic silence = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    note_scheduler_if bus ();

    note_scheduler #(
        .PRESCALE_BITS(4),
        .SYNTH_BIT(1),
        .SLOT_LEN(4),
        .GATE_LEN(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .silence(silence),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle n is the cycle in which the prescaler holds n after reset.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic at(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            total++;
            $error("FAIL wait_cycle got=%0d exp=%0d", cyc, n);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.lead_req = 1'b0;
        bus.lead_hp  = 7'd0;
        bus.bass_req = 1'b0;
        bus.bass_hp  = 7'd0;

        // Single lead note, then two empty slots.
        bus.lead_req = 1'b1;
        bus.lead_hp  = 7'd47;
        do_reset();
        at(0);
        chk("rst_active", bus.synth_active, 0);
        chk("rst_sclk", bus.synth_clk, 0);
        chk("rst_slot", bus.slot_idx, 0);
        chk("rst_hp", bus.synth_hp, 0);
        chk("rst_lack", bus.lead_ack, 0);
        chk("rst_back", bus.bass_ack, 0);
        at(2);
        chk("sclk_c2", bus.synth_clk, 1);
        at(56);
        chk("a_ack56", bus.lead_ack, 0);
        chk("a_act56", bus.synth_active, 0);
        at(57);
        chk("a_ack57", bus.lead_ack, 1);
        chk("a_hp57", bus.synth_hp, 47);
        chk("a_act57", bus.synth_active, 1);
        chk("a_slot57", bus.slot_idx, 1);
        bus.lead_req = 1'b0;
        at(58);
        chk("a_ack58", bus.lead_ack, 0);
        at(88);
        chk("a_act88", bus.synth_active, 1);
        at(89);
        chk("a_act89", bus.synth_active, 0);
        at(121);
        chk("a_slot121", bus.slot_idx, 2);
        chk("a_lack121", bus.lead_ack, 0);
        chk("a_back121", bus.bass_ack, 0);
        chk("a_hp121", bus.synth_hp, 47);
        chk("a_act121", bus.synth_active, 0);
        at(185);
        chk("a_slot185", bus.slot_idx, 3);
        chk("a_lack185", bus.lead_ack, 0);
        chk("a_back185", bus.bass_ack, 0);

        // Both requesters held high: lead, bass, lead; then silence.
        bus.lead_req = 1'b1;
        bus.lead_hp  = 7'd28;
        bus.bass_req = 1'b1;
        bus.bass_hp  = 7'd62;
        do_reset();
        at(57);
        chk("b_lack57", bus.lead_ack, 1);
        chk("b_back57", bus.bass_ack, 0);
        chk("b_hp57", bus.synth_hp, 28);
        at(121);
        chk("b_lack121", bus.lead_ack, 0);
        chk("b_back121", bus.bass_ack, 1);
        chk("b_hp121", bus.synth_hp, 62);
        at(185);
        chk("b_lack185", bus.lead_ack, 1);
        chk("b_back185", bus.bass_ack, 0);
        chk("b_hp185", bus.synth_hp, 28);
        chk("b_slot185", bus.slot_idx, 3);
        at(190);
        silence = 1'b1;
        at(191);
        chk("s_act191", bus.synth_active, 0);
        at(289);
        chk("s_act289", bus.synth_active, 0);
        chk("s_slot289", bus.slot_idx, 3);
        chk("s_ack289", bus.bass_ack, 0);
        at(290);
        silence = 1'b0;
        at(291);
        chk("s_act291", bus.synth_active, 1);
        at(316);
        chk("s_act316", bus.synth_active, 1);
        at(317);
        chk("s_act317", bus.synth_active, 0);
        at(348);
        chk("s_slot348", bus.slot_idx, 3);
        chk("s_back348", bus.bass_ack, 0);
        at(349);
        chk("s_back349", bus.bass_ack, 1);
        chk("s_hp349", bus.synth_hp, 62);
        chk("s_slot349", bus.slot_idx, 4);

        // Dropped bass request, then reset on an ack cycle.
        bus.lead_req = 1'b0;
        bus.bass_req = 1'b1;
        bus.bass_hp  = 7'd62;
        do_reset();
        at(55);
        bus.bass_req = 1'b0;
        at(57);
        chk("c_back57", bus.bass_ack, 0);
        chk("c_hp57", bus.synth_hp, 0);
        chk("c_act57", bus.synth_active, 0);
        chk("c_slot57", bus.slot_idx, 1);
        at(60);
        bus.lead_req = 1'b1;
        bus.lead_hp  = 7'd47;
        at(121);
        chk("c_lack121", bus.lead_ack, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("c_rlack", bus.lead_ack, 0);
        chk("c_rhp", bus.synth_hp, 0);
        chk("c_rslot", bus.slot_idx, 0);
        chk("c_ract", bus.synth_active, 0);
        chk("c_rsclk", bus.synth_clk, 0);
        rst_n = 1'b1;
        at(56);
        chk("c_lack56", bus.lead_ack, 0);
        at(57);
        chk("c_lack57", bus.lead_ack, 1);
        chk("c_hp57b", bus.synth_hp, 47);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
